// File: rtl/ttl_sync_counter.sv
// rtl/ttl_sync_counter.sv - chainable synchronous modulo up/down counter stage
// Generalised 74x161/163/160/191-style counter with load, P/T enables, rco and inverted-q mask.
module ttl_sync_counter #(
  parameter int unsigned          WIDTH       = 4,
  parameter longint unsigned      MODULUS     = 0,
  parameter logic [WIDTH-1:0]     INVERT_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             cnt_en_p,
  input  logic             cnt_en_t,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             tc_q
);

  // MODULUS=0 selects the natural 2^WIDTH range, so top is all ones.
  localparam logic [WIDTH-1:0] TOP = (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  logic             w_at_top;
  logic             w_at_zero;
  logic             w_wrap_pt;
  logic             w_step;
  logic [WIDTH-1:0] w_count_up;
  logic [WIDTH-1:0] w_count_dn;
  logic [WIDTH-1:0] w_count_next;
  logic             w_tc_next;

  // ">=" rather than "==" so an out-of-range load still terminates on the next up step.
  assign w_at_top   = (r_count >= TOP);
  assign w_at_zero  = (r_count == '0);
  assign w_wrap_pt  = up ? w_at_top : w_at_zero;
  assign w_step     = cnt_en_p & cnt_en_t;
  assign w_count_up = w_at_top  ? '0  : r_count + 1'b1;
  assign w_count_dn = w_at_zero ? TOP : r_count - 1'b1;

  always_comb begin
    w_count_next = r_count;
    w_tc_next    = 1'b0;
    if (load) begin
      w_count_next = d;
    end else if (w_step) begin
      w_count_next = up ? w_count_up : w_count_dn;
      w_tc_next    = w_wrap_pt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_tc    <= w_tc_next;
    end
  end

  assign q    = r_count ^ INVERT_MASK;
  assign rco  = cnt_en_t & w_wrap_pt;
  assign tc_q = r_tc;

endmodule

// File: tb/tb_ttl_sync_counter.sv
// tb/tb_ttl_sync_counter.sv - scoreboard bench for ttl_sync_counter
module tb_ttl_sync_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1, load = 1'b0, p = 1'b0, t = 1'b0, up = 1'b0;
  logic [3:0] d = '0;
  logic       c_rst = 1'b1, c_p = 1'b0;

  logic [3:0] a_q, m_q, lo_q, hi_q;
  logic       a_rco, a_tc, m_rco, m_tc, lo_rco, lo_tc, hi_rco, hi_tc;

  always #5 clk = ~clk;

  ttl_sync_counter #(.WIDTH(4), .MODULUS(0), .INVERT_MASK(4'b0101)) u_a (
    .clk(clk), .rst(rst), .load(load), .cnt_en_p(p), .cnt_en_t(t), .up(up), .d(d),
    .q(a_q), .rco(a_rco), .tc_q(a_tc));

  ttl_sync_counter #(.WIDTH(4), .MODULUS(10), .INVERT_MASK(4'b0000)) u_dec (
    .clk(clk), .rst(rst), .load(load), .cnt_en_p(p), .cnt_en_t(t), .up(up), .d(d),
    .q(m_q), .rco(m_rco), .tc_q(m_tc));

  ttl_sync_counter #(.WIDTH(4), .MODULUS(0), .INVERT_MASK(4'b0000)) u_lo (
    .clk(clk), .rst(c_rst), .load(1'b0), .cnt_en_p(c_p), .cnt_en_t(1'b1), .up(1'b1), .d(4'd0),
    .q(lo_q), .rco(lo_rco), .tc_q(lo_tc));

  ttl_sync_counter #(.WIDTH(4), .MODULUS(0), .INVERT_MASK(4'b0000)) u_hi (
    .clk(clk), .rst(c_rst), .load(1'b0), .cnt_en_p(c_p), .cnt_en_t(lo_rco), .up(1'b1), .d(4'd0),
    .q(hi_q), .rco(hi_rco), .tc_q(hi_tc));

  typedef struct {
    int         sel;
    logic [7:0] q;
    logic       rco;
    logic       tc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input int sel, input logic [7:0] eq, input logic er, input logic et,
                      input string name);
    exp_t e;
    e.sel = sel; e.q = eq; e.rco = er; e.tc = et; e.name = name;
    sb.push_back(e);
  endtask

  task automatic drive(input logic i_rst, input logic i_load, input logic i_p, input logic i_t,
                       input logic i_up, input logic [3:0] i_d);
    @(negedge clk);
    rst = i_rst; load = i_load; p = i_p; t = i_t; up = i_up; d = i_d;
    @(posedge clk);
  endtask

  // Monitor: checks every queued expectation just after the edge it describes.
  initial begin
    exp_t       e;
    logic [7:0] aq;
    logic       ar, at;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sel)
          0:       begin aq = {4'b0, a_q};  ar = a_rco;  at = a_tc;  end
          1:       begin aq = {4'b0, m_q};  ar = m_rco;  at = m_tc;  end
          default: begin aq = {hi_q, lo_q}; ar = lo_rco; at = lo_tc; end
        endcase
        total++;
        if (aq !== e.q || ar !== e.rco || at !== e.tc) begin
          bad++;
          $display("FAIL %s: got q=%h rco=%b tc=%b want q=%h rco=%b tc=%b",
                   e.name, aq, ar, at, e.q, e.rco, e.tc);
        end
      end
    end
  end

  initial begin
    int n;
    // Reset and mask
    drive(1, 0, 0, 1, 0, 0); push(0, 8'h05, 1, 0, "a_reset1"); push(1, 8'h00, 1, 0, "dec_reset1");
    drive(1, 0, 0, 1, 0, 0); push(0, 8'h05, 1, 0, "a_reset2"); push(1, 8'h00, 1, 0, "dec_reset2");

    // Decade up, 12 clocks
    drive(0, 0, 1, 1, 1, 0); push(0, 8'h04, 0, 0, "a_up1"); push(1, 8'h01, 0, 0, "dec_up1");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h02, 0, 0, "dec_up2");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h03, 0, 0, "dec_up3");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h04, 0, 0, "dec_up4");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h05, 0, 0, "dec_up5");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h06, 0, 0, "dec_up6");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h07, 0, 0, "dec_up7");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h08, 0, 0, "dec_up8");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h09, 1, 0, "dec_up9");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h00, 0, 1, "dec_up_wrap");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h01, 0, 0, "dec_up11");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h02, 0, 0, "dec_up12"); push(0, 8'h09, 0, 0, "a_up12");

    // Down, load and out-of-range
    drive(0, 1, 1, 1, 0, 3); push(1, 8'h03, 0, 0, "dec_load3");
    drive(0, 0, 1, 1, 0, 0); push(1, 8'h02, 0, 0, "dec_dn2");
    drive(0, 0, 1, 1, 0, 0); push(1, 8'h01, 0, 0, "dec_dn1");
    drive(0, 0, 1, 1, 0, 0); push(1, 8'h00, 1, 0, "dec_dn0");
    drive(0, 0, 1, 1, 0, 0); push(1, 8'h09, 0, 1, "dec_dn_wrap");
    drive(0, 0, 1, 1, 0, 0); push(1, 8'h08, 0, 0, "dec_dn8");
    drive(0, 1, 1, 1, 1, 13); push(1, 8'h0d, 1, 0, "dec_load13"); push(0, 8'h08, 0, 0, "a_load13");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h00, 0, 1, "dec_oor_wrap");

    // Priority and gating
    drive(0, 1, 1, 1, 1, 9); push(1, 8'h09, 1, 0, "dec_load9");
    drive(0, 1, 1, 1, 1, 4); push(1, 8'h04, 0, 0, "dec_load_over_cnt");
    drive(0, 1, 1, 1, 1, 9); push(1, 8'h09, 1, 0, "dec_load9b");
    drive(0, 0, 0, 1, 1, 0); push(1, 8'h09, 1, 0, "dec_p_off_hold");
    drive(0, 0, 1, 0, 1, 0); push(1, 8'h09, 0, 0, "dec_t_off_rco");

    // Reset mid-count overrides load
    drive(0, 1, 1, 1, 1, 7); push(1, 8'h07, 0, 0, "dec_load7");
    drive(1, 1, 1, 1, 1, 5); push(1, 8'h00, 0, 0, "dec_rst_load"); push(0, 8'h05, 0, 0, "a_rst_load");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h01, 0, 0, "dec_resume1");
    drive(0, 0, 1, 1, 1, 0); push(1, 8'h02, 0, 0, "dec_resume2");

    // Two-stage cascade, 300 clocks from reset
    @(negedge clk); c_rst = 1'b1; c_p = 1'b0;
    @(posedge clk); push(2, 8'h00, 0, 0, "casc_reset");
    @(negedge clk); c_rst = 1'b0; c_p = 1'b1;
    for (n = 1; n <= 300; n++) begin
      @(posedge clk);
      push(2, {4'((n / 16) % 16), 4'(n % 16)}, (n % 16) == 15, (n % 16) == 0, "casc_step");
    end
    @(negedge clk); c_p = 1'b0;
    @(posedge clk); push(2, 8'h2c, 0, 0, "casc_final_44");

    @(posedge clk); #2;
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
